// File: rtl/systolic_ctrl.sv
// Operand loader, run sequencer and result drainer for a 3x3 systolic matmul array.
// Optional RUN-phase timeout with a sticky ERR state when SYSCTRL_TIMEOUT_EN is defined.
module systolic_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    output logic [71:0]  sa_a,
    output logic [71:0]  sa_b,
    output logic         sa_start,
    output logic         sa_rst,
    input  logic         sa_done,
    input  logic [143:0] sa_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  out_data,
    output logic         out_last,
    output logic         busy,
    output logic         err
);

`ifdef SYSCTRL_TIMEOUT_EN
    typedef enum logic [2:0] {StLoad, StClr, StRun, StDrain, StErr} state_e;
`else
    typedef enum logic [1:0] {StLoad, StClr, StRun, StDrain} state_e;
`endif

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [3:0]  idx_q;
    logic [7:0]  opnd_q [18];
    logic [15:0] res_q  [9];

    logic in_ready_q;
    logic sa_start_q;
    logic sa_rst_q;
    logic out_valid_q;
    logic busy_q;

`ifdef SYSCTRL_TIMEOUT_EN
    logic [4:0] tmo_q;
    logic       err_q;
`endif

    // Flags are registered alongside the state so each output is a plain flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StLoad;
            cnt_q       <= '0;
            idx_q       <= '0;
            for (int k = 0; k < 18; k++) opnd_q[k] <= '0;
            for (int k = 0; k < 9; k++) res_q[k] <= '0;
            in_ready_q  <= 1'b1;
            sa_start_q  <= 1'b0;
            sa_rst_q    <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SYSCTRL_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                StLoad: begin
                    sa_rst_q <= 1'b0;
                    if (in_valid) begin
                        opnd_q[cnt_q] <= in_data;
                        busy_q        <= 1'b1;
                        if (cnt_q == 5'd17) begin
                            cnt_q      <= '0;
                            state_q    <= StClr;
                            in_ready_q <= 1'b0;
                            sa_rst_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                StClr: begin
                    state_q    <= StRun;
                    sa_rst_q   <= 1'b0;
                    sa_start_q <= 1'b1;
`ifdef SYSCTRL_TIMEOUT_EN
                    tmo_q      <= '0;
`endif
                end
                StRun: begin
                    if (sa_done) begin
                        for (int k = 0; k < 9; k++) res_q[k] <= sa_c[16*k +: 16];
                        state_q     <= StDrain;
                        sa_start_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        idx_q       <= '0;
`ifdef SYSCTRL_TIMEOUT_EN
                    end else if (tmo_q == 5'd30) begin
                        // 31st RUN cycle without done: give up until reset.
                        state_q    <= StErr;
                        sa_start_q <= 1'b0;
                        err_q      <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 5'd1;
`endif
                    end
                end
                StDrain: begin
                    if (out_ready) begin
                        if (idx_q == 4'd8) begin
                            state_q     <= StLoad;
                            idx_q       <= '0;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
`ifdef SYSCTRL_TIMEOUT_EN
                StErr: begin
                    state_q <= StErr;
                end
`endif
                default: begin
                    state_q <= StLoad;
                end
            endcase
        end
    end

    always_comb begin
        sa_a = '0;
        sa_b = '0;
        for (int k = 0; k < 9; k++) begin
            sa_a[8*k +: 8] = opnd_q[k];
            sa_b[8*k +: 8] = opnd_q[9 + k];
        end
    end

    assign in_ready  = in_ready_q;
    assign sa_start  = sa_start_q;
    assign sa_rst    = sa_rst_q;
    assign out_valid = out_valid_q;
    assign out_data  = res_q[idx_q];
    assign out_last  = out_valid_q && (idx_q == 4'd8);
    assign busy      = busy_q;

`ifdef SYSCTRL_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
